// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the round-robin shared logic unit.
// Opcode encoding and a reference bitwise-op function.
package logic_unit_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    OP_INV   = 2'd0,
    OP_AND2  = 2'd1,
    OP_NAND2 = 2'd2,
    OP_MUX2  = 2'd3
  } op_e;

  function automatic logic [MAX_W-1:0] logic_op(
    input op_e              op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic [MAX_W-1:0] c
  );
    logic [MAX_W-1:0] r;
    r = '0;
    unique case (1'b1)
      op == OP_INV:   r = ~a;
      op == OP_AND2:  r = a & b;
      op == OP_NAND2: r = ~(a & b);
      op == OP_MUX2:  r = c[0] ? b : a;
      default:        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_gates.sv
// Bitwise gate cells used by the shared logic unit datapath.
// Inv, And2 and Nand2 over a WIDTH-bit vector.
module Inv #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = ~a;
endmodule

module And2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

module Nand2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a & b);
endmodule

// File: rtl/logic_unit_rr_arbiter.sv
// Round-robin arbiter: searches valid upward from rr_ptr, wrapping.
// Pointer moves past the winner only when a grant is taken.
module logic_unit_rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   valid,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N))
        sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!found && valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (advance && found)
      rr_ptr <= (grant_id == IDW'(N-1)) ? '0
                                        : grant_id + IDW'(1);
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// N requesters share one WIDTH-bit logic unit via round-robin grant.
// Single registered result stage with valid/ready back-pressure.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int N     = 4,
  localparam int IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [2*N-1:0]     req_op,
  input  logic [WIDTH*N-1:0] req_a,
  input  logic [WIDTH*N-1:0] req_b,
  input  logic [WIDTH*N-1:0] req_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [WIDTH-1:0]   rsp_data
);

  logic             can_accept;
  logic             xfer;
  logic [N-1:0]     grant;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             c_sel;
  logic [1:0]       op_raw;
  op_e              op_sel;
  logic [WIDTH-1:0] inv_y;
  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] nand_y;
  logic [WIDTH-1:0] result;
  logic             unused_c;

  assign can_accept = !rsp_valid || rsp_ready;

  logic_unit_rr_arbiter #(.N(N)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (req_valid),
    .advance  (can_accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // rst_n gating keeps ready low while reset is held
  assign req_ready = grant & {N{can_accept & rst_n}};
  assign xfer      = |req_ready;

  assign a_sel  = req_a[int'(grant_id)*WIDTH +: WIDTH];
  assign b_sel  = req_b[int'(grant_id)*WIDTH +: WIDTH];
  assign c_sel  = req_c[int'(grant_id)*WIDTH];
  assign op_raw = req_op[2*int'(grant_id) +: 2];
  assign op_sel = op_e'(op_raw);

  // only bit 0 of each c operand matters
  assign unused_c = ^req_c;

  Inv #(.WIDTH(WIDTH)) u_inv (
    .a (a_sel),
    .y (inv_y)
  );

  And2 #(.WIDTH(WIDTH)) u_and2 (
    .a (a_sel),
    .b (b_sel),
    .y (and_y)
  );

  Nand2 #(.WIDTH(WIDTH)) u_nand2 (
    .a (a_sel),
    .b (b_sel),
    .y (nand_y)
  );

  always_comb begin
    result = '0;
    unique case (1'b1)
      op_sel == OP_INV:   result = inv_y;
      op_sel == OP_AND2:  result = and_y;
      op_sel == OP_NAND2: result = nand_y;
      op_sel == OP_MUX2:  result = c_sel ? b_sel : a_sel;
      default:            result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_id;
      rsp_data  <= result;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: vector table, scoreboard queue,
// and directed sequences for stall, wrap and mid-stream reset.
module tb_logic_unit_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic [W*N-1:0] req_c;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;

  int errors = 0;
  int checks = 0;

  logic_unit_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model_op(input logic [1:0] op,
      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    case (op)
      2'd0:    return ~a;
      2'd1:    return a & b;
      2'd2:    return ~(a & b);
      default: return c[0] ? b : a;
    endcase
  endfunction

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op,
      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    req_op[2*i +: 2] = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_c[i*W +: W]  = c;
  endtask

  typedef struct {
    int          id;
    logic [63:0] data;
  } exp_t;

  exp_t sbq[$];
  int   m_ptr;
  logic m_valid;
  bit   sb_en;

  always @(negedge clk) begin
    int         g;
    logic [N-1:0] er;
    exp_t       e;
    if (sb_en && rst_n) begin
      chk("sb_valid", rsp_valid, m_valid);
      if (m_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got empty queue required entry");
        end else begin
          chk("sb_id", rsp_id, sbq[0].id);
          chk("sb_data", rsp_data, sbq[0].data);
        end
      end
      g  = model_grant(req_valid, m_ptr);
      er = '0;
      if ((!m_valid || rsp_ready) && g >= 0) er[g] = 1'b1;
      chk("sb_ready", req_ready, er);
      if (m_valid && rsp_ready && sbq.size() > 0) void'(sbq.pop_front());
      if (er != '0) begin
        e.id   = g;
        e.data = model_op(req_op[2*g +: 2], req_a[g*W +: W],
                          req_b[g*W +: W], req_c[g*W +: W]);
        sbq.push_back(e);
        m_ptr   = (g + 1) % N;
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic clear_model();
    sbq.delete();
    m_ptr   = 0;
    m_valid = 1'b0;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    rst_n = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_en = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];
  int   seq_fair[4];

  initial begin
    vecs[0] = '{0, 2'd1, 64'hFF00FF00FF00FF00, 64'h0FF00FF00FF00FF0,
                64'h0, 64'h0F000F000F000F00};
    vecs[1] = '{1, 2'd3, 64'h1, 64'h2, 64'h1, 64'h2};
    vecs[2] = '{2, 2'd3, 64'h1, 64'h2, 64'h2, 64'h1};
    vecs[3] = '{3, 2'd2, '1, '1, 64'h0, 64'h0};
    vecs[4] = '{1, 2'd0, 64'h0123456789ABCDEF, 64'h0, 64'h0,
                64'hFEDCBA9876543210};
    vecs[5] = '{2, 2'd1, 64'hF0F0F0F0F0F0F0F0, 64'hFFFF0000FFFF0000,
                64'h0, 64'hF0F00000F0F00000};
    vecs[6] = '{0, 2'd2, 64'h0, '1, 64'h0, '1};
    seq_fair = '{3, 0, 3, 0};

    rst_n     = 1'b0;
    sb_en     = 1'b0;
    clear_model();
    req_valid = '1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    rsp_ready = 1'b1;
    #2;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_id", rsp_id, 2'd0);
    chk("rst_data", rsp_data, 64'h0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].c);
      req_valid = 4'b0001 << vecs[v].id;
      #1;
      chk("vec_ready", req_ready, 4'b0001 << vecs[v].id);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("vec_valid", rsp_valid, 1'b1);
      chk("vec_id", rsp_id, vecs[v].id);
      chk("vec_data", rsp_data, vecs[v].exp);
      @(posedge clk); #1;
    end

    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'd0, 64'(i), 64'h0, 64'h0);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rr_id", rsp_id, k % N);
      chk("rr_data", rsp_data, ~64'(k % N));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    rsp_ready = 1'b0;
    set_req(2, 2'd0, 64'h5, 64'h0, 64'h0);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    set_req(1, 2'd1, 64'hFFFF, 64'h0F0F, 64'h0);
    req_valid = 4'b0010;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_id", rsp_id, 2'd2);
      chk("bp_data", rsp_data, ~64'h5);
      chk("bp_ready", req_ready, 4'b0000);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_id", rsp_id, 2'd1);
    chk("bp_next_data", rsp_data, 64'h0F0F);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    do_reset();
    set_req(2, 2'd0, 64'h2, 64'h0, 64'h0);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    set_req(3, 2'd0, 64'h3, 64'h0, 64'h0);
    set_req(0, 2'd0, 64'h0, 64'h0, 64'h0);
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("fair_id", rsp_id, seq_fair[k]);
      if (k == 0) chk("fair_wrap_ptr", dut.u_arb.rr_ptr, 2'd0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    rsp_ready = 1'b0;
    set_req(0, 2'd0, 64'h7, 64'h0, 64'h0);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    set_req(1, 2'd1, 64'hAAAA, 64'h00FF, 64'h0);
    set_req(3, 2'd0, 64'h3, 64'h0, 64'h0);
    req_valid = 4'b1010;
    @(posedge clk); #3;
    sb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", rsp_valid, 1'b0);
    chk("mrst_data", rsp_data, 64'h0);
    chk("mrst_ready", req_ready, 4'b0000);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    sb_en     = 1'b1;
    #1;
    chk("mrst_first_ready", req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_first_id", rsp_id, 2'd1);
    chk("mrst_first_data", rsp_data, 64'h00AA);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (INV, AND2, NAND2, MUX2) between N requesters.
- Round-robin arbitration, one grant per cycle, valid/ready handshake on both sides.
- Result is held in a single registered output stage with back-pressure.
- Sits between issuing agents (test sequencers, future ALU front-end) and the gate library.

Parameters:
- WIDTH, 64, datapath width of operands and result.
- N, 4, number of requesters (2..16).
- IDW, $clog2(N), width of requester id (derived localparam, not overridable).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N  per-requester request valid
- req_ready  output  N  per-requester accept; at most one bit set per cycle
- req_op  input  2*N  per-requester opcode, requester i at bits [2i+1:2i]
- req_a  input  WIDTH*N  operand a, requester i at slice i
- req_b  input  WIDTH*N  operand b
- req_c  input  WIDTH*N  operand c; only bit 0 is used (MUX2 select)
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  IDW  index of the requester that owns the result
- rsp_data  output  WIDTH  result

Behaviour:
- Reset (async assert, sync deassert by the system):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0.
  - req_ready=0 while rst_n=0.
- Opcodes:
  - 0 INV: ~a
  - 1 AND2: a&b
  - 2 NAND2: ~(a&b)
  - 3 MUX2: c[0] ? b : a
- can_accept = !rsp_valid || rsp_ready.
- Grant selection:
  - Search req_valid starting at index rr_ptr, wrapping upward; the first set bit wins.
  - req_ready[g] = can_accept && req_valid[g]; all other bits are 0.
  - req_ready is combinational from req_valid; requesters must not make valid depend on ready.
- Transfer on req_valid[g]&&req_ready[g]:
  - Next edge: rsp_valid=1, rsp_id=g, rsp_data=op(g).
  - rr_ptr = (g+1) mod N, wrapping N-1 -> 0.
  - Latency is 1 cycle from accept to rsp_valid.
- No grant: rsp_valid&&rsp_ready -> rsp_valid=0 next edge. rsp_data and rsp_id are left unchanged.
- Simultaneous drain and accept (rsp_valid&&rsp_ready and a new grant): output is overwritten with the new result and rsp_valid stays 1. Full throughput is 1 op/cycle.
- Stall (rsp_valid&&!rsp_ready): rsp_valid, rsp_id and rsp_data hold stable, and req_ready is all 0.
- Requester handshake rule: once a requester raises req_valid, it holds it and its operands stable until its req_ready is seen.
- Fairness: a requester holding valid is granted within N accepting cycles.
- rr_ptr changes only on a grant.
- Reset mid-operation: any in-flight result is discarded immediately (rsp_valid drops asynchronously) and arbitration restarts at requester 0.
- Implementation: two always blocks, one for the output register and one for rr_ptr.

Decomposition:
- Package logic_unit_pkg holds:
  - op_e enum {OP_INV=2'd0, OP_AND2, OP_NAND2, OP_MUX2};
  - the function logic_op(op, a, b, c) returning WIDTH bits.
- Sub-module logic_unit_rr_arbiter #(N) contains:
  - ports: clk, rst_n, valid[N], advance, grant[N] (one-hot), grant_id[IDW];
  - rr_ptr state and the rotate/priority search.
  - advance = can_accept; the top-level ANDs it into req_ready.
- Datapath selects operands by grant_id, then instantiates the existing gate cells Inv, And2 and Nand2 plus a 4:1 op select.

Test Plan:
- Single op: req_valid=0001, op=AND2, a=0xFF00FF00FF00FF00, b=0x0FF00FF00FF00FF0, rsp_ready=1 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x0F000F000F000F00.
- Round-robin: req_valid=1111 held, rsp_ready=1, each requester op=INV with a=i -> rsp_id sequence 0,1,2,3,0 on consecutive cycles; rsp_data=~i.
- Back-pressure: result pending and rsp_ready=0 for 5 cycles -> rsp_valid/rsp_id/rsp_data stable and req_ready=0000; raise rsp_ready -> next grant in the same cycle and the new result on the following edge.
- MUX2/NAND2:
  - MUX2, c=1, a=0x1, b=0x2 -> 0x2.
  - MUX2, c=0x2 (bit0=0) -> 0x1.
  - NAND2, a=b=all-ones -> 0.
- Fairness and wrap: requester 3 continuously valid; requester 0 raises valid when rr_ptr=3 -> grant order 3, 0, 3, 0, and rr_ptr wraps 3 -> 0.
- Reset mid-stream: assert rst_n=0 while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0, rsp_data=0 and req_ready=0 immediately; after release with req_valid=1010 -> first grant goes to requester 1.
